// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, full/empty and almost flags, registered read data and an illegal-access error flag.
// Read latency 1 cycle; rejected reads and writes leave the FIFO unchanged. FIFO_STICKY_ERR_EN makes error hold until reset.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     error
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             error_q, error_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             af_q, af_d, ae_q, ae_d;
    logic             do_wr, do_rd, illegal;

    always_comb begin
        // Full implies non-empty, so a paired read always frees the slot being written.
        do_rd   = ren && !empty_q;
        do_wr   = wen && (!full_q || ren);
        illegal = (ren && empty_q) || (wen && full_q && !ren);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;

        if (do_wr) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (do_rd) begin
            rptr_d = rptr_q + PW'(1);
            dout_d = mem_q[rptr_q];
        end

        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

`ifdef FIFO_STICKY_ERR_EN
        error_d = error_q || illegal;
`else
        error_d = illegal;
`endif
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            error_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
            ae_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            error_q <= error_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    assign dout         = dout_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign error        = error_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at WIDTH=8, DEPTH=8: fill/drain, overflow, underflow,
// simultaneous access on empty and full, pointer wrap, async reset and error-pulse behaviour.
module tb_fifo_sync_param;
`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, error;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    bit sticky_set = 1'b0;

    fifo_sync_param #(.WIDTH(8), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .ren          (ren),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clocked access; error is checked after every edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input bit ill);
        @(negedge clk);
        wen = w;
        ren = r;
        din = d;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        if (ill) sticky_set = 1'b1;
        chk("error", 32'(error), (ill || (STICKY && sticky_set)) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_state(input string tag, input int c, input logic f, input logic e,
                             input logic af, input logic ae);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".full"},  32'(full),  32'(f));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".af"},    32'(almost_full),  32'(af));
        chk({tag, ".ae"},    32'(almost_empty), 32'(ae));
    endtask

    logic [7:0] fill_vals [8] = '{8'd56, 8'd11, 8'd42, 8'd10, 8'd23, 8'd20, 8'd6, 8'd85};

    initial begin
        // Reset held for a cycle
        @(posedge clk);
        #1;
        chk("rst.dout", 32'(dout), 0);
        chk("rst.error", 32'(error), 0);
        chk_state("rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with the reference sequence
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, fill_vals[i], 1'b0);
            chk("fill.count", 32'(count), 32'(i + 1));
            chk("fill.af", 32'(almost_full), (i + 1 >= 7) ? 32'd1 : 32'd0);
            chk("fill.ae", 32'(almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
        end
        chk_state("full", 8, 1'b1, 1'b0, 1'b1, 1'b0);

        // Overflow: write-only on full is dropped, error for one cycle
        step(1'b1, 1'b0, 8'd45, 1'b1);
        chk("ovf.count", 32'(count), 8);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        chk("ovf.full", 32'(full), 1);

        // Drain: 45 must not appear
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd0, 1'b0);
            chk("drain.dout", 32'(dout), 32'(fill_vals[i]));
        end
        chk_state("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Underflow: read on empty, dout holds 85
        step(1'b0, 1'b1, 8'd0, 1'b1);
        chk("unf.dout", 32'(dout), 85);
        chk("unf.count", 32'(count), 0);
        step(1'b0, 1'b0, 8'd0, 1'b0);

        // Simultaneous on empty: write lands, read rejected
        step(1'b1, 1'b1, 8'd12, 1'b1);
        chk("se.count", 32'(count), 1);
        chk("se.dout", 32'(dout), 85);
        step(1'b0, 1'b1, 8'd0, 1'b0);
        chk("se.rd", 32'(dout), 12);
        chk("se.count0", 32'(count), 0);

        // Refill from pointer 1 so both pointers wrap
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(100 + i), 1'b0);
        end
        chk_state("refull", 8, 1'b1, 1'b0, 1'b1, 1'b0);

        // Simultaneous on full: oldest out, 77 in, no error
        step(1'b1, 1'b1, 8'd77, 1'b0);
        chk("sf.dout", 32'(dout), 100);
        chk("sf.count", 32'(count), 8);
        chk("sf.full", 32'(full), 1);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd0, 1'b0);
            chk("sf.drain", 32'(dout), 32'(100 + i));
        end
        step(1'b0, 1'b1, 8'd0, 1'b0);
        chk("sf.last77", 32'(dout), 77);
        chk("sf.empty", 32'(empty), 1);

        // Async reset mid-cycle, no clock edge needed
        step(1'b1, 1'b0, 8'd33, 1'b0);
        step(1'b1, 1'b0, 8'd34, 1'b0);
        chk("pre.count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.dout", 32'(dout), 0);
        chk("arst.error", 32'(error), 0);
        chk_state("arst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        sticky_set = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First access after reset sees an empty FIFO
        step(1'b0, 1'b1, 8'd0, 1'b1);
        chk("post.dout", 32'(dout), 0);

        // Twenty legal operations after the illegal one
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(i + 1), 1'b0);
            step(1'b0, 1'b1, 8'd0, 1'b0);
            chk("legal.dout", 32'(dout), 32'(i + 1));
        end
        chk("legal.count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 8x8 FIFO.
- Generalises data width and depth.
- Adds simultaneous read+write, occupancy count, and full/empty/almost-full/almost-empty flags.
- Used as the general buffer between producer/consumer blocks in one clock domain; drop-in for the old FIFO when WIDTH=8, DEPTH=8.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
wen  input  1  write request, sampled at posedge clk
ren  input  1  read request, sampled at posedge clk
din  input  WIDTH  write data
dout  output  WIDTH  read data, registered
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
error  output  1  illegal-access indication, registered

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; clock and reset ports are named clk and rst_n.
- Reset (rst_n=0, immediate, no clock needed):
  - dout=0, error=0, count=0, empty=1, full=0, almost_empty=1.
  - almost_full=(AF_LEVEL==0).
  - Read and write pointers are cleared to 0; storage contents are don't-care.
- Reset mid-operation discards all contents. The first access after rst_n rises sees an empty FIFO.
- Storage: DEPTH x WIDTH register array. Read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty are derived from count, not from pointer compare.
- Read (ren=1, not empty):
  - dout <= mem[rptr] at the same posedge.
  - Data is visible the cycle after the request (latency 1).
  - rptr increments.
- Write (wen=1, not full): mem[wptr] <= din; wptr increments.
- No read performed: dout holds its last value.
- Simultaneous wen=1, ren=1:
  - Not empty, not full: both performed, count unchanged.
  - Full: both performed (read frees the slot written), count stays DEPTH, error=0.
  - Empty: write performed, read rejected, count becomes 1, error=1, dout holds.
- Illegal accesses:
  - ren=1 while empty (without the simultaneous-write case above being legal for the read): read ignored, dout holds.
  - wen=1 while full without ren: write ignored, storage and pointers unchanged.
  - Either case: error=1 for the next cycle.
- error: registered pulse, high for exactly the cycle after an illegal access, otherwise 0.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. All flags are registered/derived from count and update the same edge as count.
- Flags and count never go out of range; no wrap of count.

Optional Feature:
- Macro FIFO_STICKY_ERR_EN.
- Defined: error is sticky. It sets on the first illegal access and stays 1 until rst_n is asserted. Normal operation continues unaffected.
- Undefined: error is the one-cycle pulse described above.

Test Plan:
- Reset then idle: rst_n low 1 cycle -> dout=0, count=0, empty=1, full=0, error=0. Assert rst_n async mid-cycle -> outputs clear without a clock edge.
- Fill/drain (WIDTH=8, DEPTH=8):
  - Write 56,11,42,10,23,20,6,85 -> full=1, count=8, almost_full from count 7.
  - Then read 8 -> dout sequence 56,11,42,10,23,20,6,85, one per cycle after each request; empty=1 at end.
- Overflow: on full FIFO, wen=1 din=45, ren=0 -> error=1 next cycle only. count stays 8; later reads return 56-first order with 45 absent.
- Underflow: empty FIFO, ren=1 -> error=1 next cycle, dout holds prior value. Simultaneous wen=1 din=12 ren=1 on empty -> count=1, error=1, next read returns 12.
- Simultaneous on full: wen=1 din=77, ren=1 -> dout=oldest entry, count stays 8, error=0. 77 appears as eighth subsequent read; pointer wrap exercised.
- With FIFO_STICKY_ERR_EN: one underflow then 20 legal ops -> error stays 1 until rst_n=0; without macro, error low after one cycle.
